// File: rtl/ones_count_arbiter.sv
// Round-robin front end that shares a single ones-count engine among N requesters.
// One operation per grant; the watchdog turns a silent engine into an error response.
//
// state | meaning
// IDLE  | arbitrating; grants the first requester at or after ptr
// START | one-cycle engine start pulse with the latched operand
// BUSY  | waiting for the engine's done pulse or watchdog expiry
// RESP  | one-cycle response to the owner; ptr advances past it
module ones_count_arbiter #(
  parameter int N       = 4,
  parameter int W       = 30,
  parameter int TIMEOUT = 64,
  localparam int CW     = $clog2(W)
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    resp_valid,
  output logic [CW-1:0]   resp_count,
  output logic            resp_err,
  output logic            busy,
  output logic            eng_start,
  output logic [W-1:0]    eng_data,
  input  logic            eng_done,
  input  logic [CW-1:0]   eng_count
);

  localparam int IW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT);
  // Expiry compares the pre-increment value so RESP lands TIMEOUT cycles after eng_start.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [W-1:0]    operand;
  logic [WDW-1:0]  watchdog;
  logic [CW-1:0]   count;
  logic            err;

  logic [IW-1:0]   sel;
  logic            any_req;

  always_comb begin
    logic [IW:0]   j;
    logic [IW-1:0] idx;
    sel     = '0;
    any_req = 1'b0;
    j       = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      idx = j[IW-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      operand  <= '0;
      watchdog <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            operand <= req_data[int'(sel)*W +: W];
            owner   <= sel;
            state   <= START;
          end
        end
        START: begin
          watchdog <= '0;
          state    <= BUSY;
        end
        BUSY: begin
          if (eng_done) begin
            count <= eng_count;
            err   <= 1'b0;
            state <= RESP;
          end else if (watchdog == WD_LAST) begin
            count <= '0;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        RESP: begin
          ptr   <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    if (state == IDLE && any_req && reset_L) gnt[sel] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[owner] = 1'b1;
  end

  assign resp_count = (state == RESP) ? count : '0;
  assign resp_err   = (state == RESP) && err;
  assign busy       = (state != IDLE);
  assign eng_start  = (state == START);
  assign eng_data   = (state == IDLE) ? '0 : operand;

endmodule

// File: tb/tb_ones_count_arbiter.sv
// Directed bench for ones_count_arbiter with a behavioural ones-count engine
// whose latency and hang behaviour are steered by the stimulus.
module tb_ones_count_arbiter;

  localparam int N       = 4;
  localparam int W       = 30;
  localparam int TIMEOUT = 64;
  localparam int CW      = $clog2(W);

  logic            clk = 1'b0;
  logic            reset_L;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    resp_valid;
  logic [CW-1:0]   resp_count;
  logic            resp_err;
  logic            busy;
  logic            eng_start;
  logic [W-1:0]    eng_data;
  logic            eng_done;
  logic [CW-1:0]   eng_count;

  logic [W-1:0]    data [N];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_resp = 0;

  // engine model controls
  int     eng_lat  = 31;
  bit     eng_hang = 1'b0;
  logic   spur_done = 1'b0;
  logic   eng_busy, eng_done_r;
  int     eng_dly;
  logic [CW-1:0] eng_res;

  ones_count_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_count (resp_count),
    .resp_err   (resp_err),
    .busy       (busy),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .eng_count  (eng_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = data[i];
  end

  // done arrives eng_lat cycles after the cycle in which eng_start is seen
  always @(posedge clk) begin
    if (!reset_L) begin
      eng_busy   <= 1'b0;
      eng_dly    <= 0;
      eng_done_r <= 1'b0;
      eng_res    <= '0;
    end else begin
      eng_done_r <= 1'b0;
      if (eng_start) begin
        eng_busy <= 1'b1;
        eng_dly  <= eng_lat - 1;
        eng_res  <= CW'($countones(eng_data));
      end else if (eng_busy) begin
        if (eng_dly == 1) begin
          eng_busy <= 1'b0;
          if (!eng_hang) eng_done_r <= 1'b1;
        end
        eng_dly <= eng_dly - 1;
      end
    end
  end

  assign eng_done  = eng_done_r | spur_done;
  assign eng_count = eng_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Wait for a grant, follow it through start and response, and check timing and routing.
  task automatic serve(input int idx, input logic [CW-1:0] cnt, input logic e, input int lat,
                       input bit chk_gap, input logic [N-1:0] drop, input bit spur);
    int g_cyc;
    int k;
    #1;
    k = 0;
    while (gnt == '0 && k < 100) begin step(); k++; end
    if (gnt == '0) begin check("gnt_timeout", 64'd0, 64'd1); return; end
    g_cyc = cyc;
    check("gnt_onehot", gnt, 64'(1 << idx));
    if (chk_gap) check("gnt_gap", 64'(g_cyc - last_resp), 64'd1);
    step();
    req = req & ~drop;
    if (spur) spur_done = 1'b1;
    check("eng_start", {eng_start, eng_data}, {1'b1, data[idx]});
    step();
    spur_done = 1'b0;
    check("eng_start_pulse", {63'd0, eng_start}, 64'd0);
    k = 0;
    while (resp_valid == '0 && k < TIMEOUT + 10) begin step(); k++; end
    if (resp_valid == '0) begin check("resp_timeout", 64'd0, 64'd1); return; end
    check("resp_valid", resp_valid, 64'(1 << idx));
    check("resp_count", resp_count, cnt);
    check("resp_err", resp_err, e);
    check("resp_latency", 64'(cyc - g_cyc), 64'(lat));
    last_resp = cyc;
  endtask

  initial begin
    logic [N-1:0] seen;
    reset_L = 1'b0;
    req     = '0;
    for (int i = 0; i < N; i++) data[i] = '0;
    repeat (3) step();
    check("reset_outputs", {busy, gnt, resp_valid, resp_err, resp_count, eng_start, eng_data}, 64'd0);

    // round robin, all requesters pending from reset
    data[0] = 30'h0000000F;
    data[1] = 30'h3FFFFFFF;
    data[2] = 30'h15555555;
    data[3] = 30'h20000001;
    req = 4'hF;
    repeat (2) step();
    reset_L = 1'b1;
    serve(0, 5'd4,  1'b0, 33, 1'b0, 4'b0000, 1'b0);
    serve(1, 5'd30, 1'b0, 33, 1'b1, 4'b0000, 1'b0);
    serve(2, 5'd15, 1'b0, 33, 1'b1, 4'b0000, 1'b0);
    serve(3, 5'd2,  1'b0, 33, 1'b1, 4'b0000, 1'b0);
    serve(0, 5'd4,  1'b0, 33, 1'b1, 4'b1111, 1'b0);
    repeat (3) step();
    check("idle_quiet", {busy, gnt, resp_valid, resp_err, resp_count, eng_data}, 64'd0);

    // single requester, three operands
    data[2] = 30'h3FFFFFFF; req = 4'b0100;
    serve(2, 5'd30, 1'b0, 33, 1'b0, 4'b0100, 1'b0);
    step();
    data[2] = 30'h00000000; req = 4'b0100;
    serve(2, 5'd0,  1'b0, 33, 1'b0, 4'b0100, 1'b0);
    step();
    data[2] = 30'h15555555; req = 4'b0100;
    serve(2, 5'd15, 1'b0, 33, 1'b0, 4'b0100, 1'b0);
    step();

    // ptr=3 with only req[1:0]: wrap to 0, then 1
    data[0] = 30'h00000007; data[1] = 30'h00000003; req = 4'b0011;
    serve(0, 5'd3, 1'b0, 33, 1'b0, 4'b0001, 1'b0);
    serve(1, 5'd2, 1'b0, 33, 1'b1, 4'b0010, 1'b0);
    step();

    // watchdog abort, then normal service, then done on the final watchdog cycle
    eng_hang = 1'b1;
    data[1] = 30'h000003FF; req = 4'b0010;
    serve(1, 5'd0, 1'b1, TIMEOUT + 1, 1'b0, 4'b0010, 1'b0);
    eng_hang = 1'b0;
    step();
    data[3] = 30'h00000001; req = 4'b1000;
    serve(3, 5'd1, 1'b0, 33, 1'b0, 4'b1000, 1'b0);
    step();
    eng_lat = TIMEOUT - 1;
    data[0] = 30'h3FFFFFFF; req = 4'b0001;
    serve(0, 5'd30, 1'b0, TIMEOUT + 1, 1'b0, 4'b0001, 1'b0);
    eng_lat = 31;
    step();

    // spurious done in IDLE, then during START
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    check("spur_idle", {busy, resp_valid, resp_count}, 64'd0);
    data[2] = 30'h15555555; req = 4'b0100;
    serve(2, 5'd15, 1'b0, 33, 1'b0, 4'b0100, 1'b1);
    step();

    // reset during BUSY aborts silently and clears ptr
    data[2] = 30'h0000FFFF; req = 4'b0100;
    #1;
    for (int k = 0; k < 10 && gnt == '0; k++) step();
    check("mid_gnt", gnt, 64'h4);
    step();
    req = '0;
    repeat (5) step();
    check("mid_busy", {63'd0, busy}, 64'd1);
    reset_L = 1'b0;
    step();
    reset_L = 1'b1;
    #1;
    check("mid_reset_outputs", {busy, gnt, resp_valid, resp_err, resp_count, eng_start, eng_data}, 64'd0);
    seen = '0;
    for (int k = 0; k < 40; k++) begin step(); seen |= resp_valid; end
    check("mid_no_resp", seen, 64'd0);
    data[0] = 30'h00000003; data[3] = 30'h0000001F; req = 4'b1001;
    serve(0, 5'd2, 1'b0, 33, 1'b0, 4'b0001, 1'b0);
    serve(3, 5'd5, 1'b0, 33, 1'b1, 4'b1000, 1'b0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ones_count_arbiter.md
Name: ones_count_arbiter

Overview:
Shares one ones-count engine (W-bit operand in, popcount out, start/done handshake) among N requesters. Grants requesters round-robin and launches one operation per grant with a one-cycle start pulse. Captures the engine result on its done pulse and returns it to the granted requester. A watchdog aborts an operation if the engine never reports done. Sits between client blocks and the single shared engine instance.

Parameters:
N, 4, number of requesters (2..8)
W, 30, operand width; must not be a power of two so the max count fits in CW=$clog2(W) bits
TIMEOUT, 64, cycles allowed from eng_start to eng_done before abort (must be > W+2)

Ports:
clk  input  1  clock
reset_L  input  1  synchronous active-low reset
req  input  N  req[i]=1: requester i has an operand pending
req_data  input  N*W  operand of requester i in bits [i*W +: W]
gnt  output  N  one-hot, one-cycle; operand of that requester is sampled this cycle
resp_valid  output  N  one-hot, one-cycle; result for requester i
resp_count  output  CW  popcount result, valid while any resp_valid bit is high, else 0
resp_err  output  1  with resp_valid: 1 = watchdog abort, resp_count=0
busy  output  1  1 in every state except IDLE
eng_start  output  1  to engine d_in_ready; one-cycle pulse
eng_data  output  W  to engine d_in; latched operand, 0 when idle
eng_done  input  1  from engine dor; one-cycle pulse, eng_count final that cycle
eng_count  input  CW  from engine d_out

Behaviour:
- Reset is synchronous active-low: on a clk edge with reset_L=0 -> state IDLE, ptr=0, owner=0, latched operand=0, watchdog=0. All outputs 0.
- Reset has priority over all other events and aborts any in-flight operation with no response issued. The engine must be reset in the same cycle by the top level.
- FSM states: IDLE, START, BUSY, RESP.
- IDLE:
  - If req!=0, select the first requester with req set, searching from index ptr upward and wrapping modulo N.
  - gnt[sel]=1 combinationally that cycle. On the edge: latch req_data[sel] and owner=sel, then go to START.
  - If req=0, stay in IDLE with gnt=0.
- START: eng_start=1 and eng_data=latched operand for exactly one cycle. Clear the watchdog, then go to BUSY.
- BUSY:
  - eng_start=0; eng_data holds the latched operand; the watchdog increments each cycle.
  - On eng_done=1: capture eng_count, then go to RESP with err=0.
  - Otherwise, if the watchdog reaches TIMEOUT-1: go to RESP with err=1 and count=0.
  - If both happen in the same cycle, eng_done wins (err=0).
- RESP:
  - resp_valid[owner]=1, resp_count=captured count, resp_err=err, all for one cycle.
  - ptr <= (owner+1) mod N, then go to IDLE.
- No grant is issued in START, BUSY or RESP. Requests are only evaluated in IDLE, so the earliest re-grant is the cycle after RESP.
- Requester protocol:
  - A requester may drop req after seeing gnt.
  - If req stays high after its resp_valid, it is treated as a new request and arbitrated normally.
  - A req dropped before being granted is simply not served.
- eng_done in IDLE, START or RESP is spurious: ignore it, and no state change occurs.
- Latency with a W=30 engine:
  - gnt at cycle 0, eng_start at cycle 1.
  - Engine asserts done 31 cycles after it loads, so eng_done arrives at cycle 32.
  - resp_valid at cycle 33.
- ptr updates only on RESP, including RESP with err=1. This guarantees that no requester is starved by a faulty engine.

Test Plan:
- Single request, W=30: req[2]=1 with data 0x3FFFFFFF -> gnt[2] at cycle 0, eng_start at cycle 1, resp_valid[2] at cycle 33 with resp_count=30 and resp_err=0. Then operand 0x00000000 -> count 0; operand 0x15555555 -> count 15.
- Round-robin with all four requesters holding req=1 continuously from reset: grants occur in order 0,1,2,3,0. Each next gnt comes exactly one cycle after the previous resp_valid, and each resp_valid is routed only to its own index.
- Wrap and skip with ptr=3 after serving requester 2, where only req[1] and req[0] are set -> gnt[0] first, then gnt[1].
- Watchdog: engine model never asserts eng_done -> resp_valid[owner]=1 with resp_err=1 and resp_count=0, exactly TIMEOUT cycles after eng_start. The next request is then served normally. A second case puts eng_done on the final watchdog cycle -> resp_err=0.
- Spurious done: eng_done pulsed while IDLE, and again during a START cycle -> no state change, and no resp_valid until the real done arrives.
- Reset mid-operation: reset_L=0 for one cycle during BUSY -> the next cycle has all outputs 0 and the FSM is in IDLE. No resp_valid is issued for the aborted operation, and after reset a req[3] is granted with ptr=0 semantics.
